// File: rtl/pipe_ctrl.sv
// pipe_ctrl: valid/allowin handshake controller for a linear pipeline.
//
// A payload enters stage 0 (youngest) and walks one stage per clock toward
// stage STAGES-1 (oldest), leaving through the out_* port. A stall on a stage
// holds it and everything younger; a flush kills a stage and everything
// younger. retire_cnt counts payloads consumed downstream.
//
// Ports
//   clk          single clock, rising edge
//   reset        asynchronous active-high reset
//   in_valid     upstream offers in_data to stage 0
//   in_data      payload offered to stage 0
//   in_ready     stage 0 accepts in_data this cycle
//   stall        per-stage hold request (bit i: stage i not ready to go)
//   flush        per-stage kill (bit i: invalidate stages 0..i)
//   out_valid    oldest stage holds a payload ready to leave
//   out_data     oldest stage payload
//   out_ready    downstream consumes out_data this cycle
//   stage_valid  valid bit of every stage
//   stage_data   payloads, stage i at [i*WIDTH +: WIDTH]
//   retire_cnt   payloads consumed at the output, wraps at 2^32

module pipe_ctrl #(
    parameter int STAGES = 5,
    parameter int WIDTH  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      in_ready,
    input  logic [STAGES-1:0]         stall,
    input  logic [STAGES-1:0]         flush,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    input  logic                      out_ready,
    output logic [STAGES-1:0]         stage_valid,
    output logic [STAGES*WIDTH-1:0]   stage_data,
    output logic [31:0]               retire_cnt
);

    logic [STAGES-1:0] valid_q;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [31:0]       retire_q;

    logic [STAGES-1:0] ready_go;
    logic [STAGES:0]   allowin;
    logic [STAGES-1:0] kill;

    // allowin ripples from the output back toward stage 0.
    always_comb begin
        ready_go        = ~stall;
        allowin         = '0;
        allowin[STAGES] = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            allowin[i] = !valid_q[i] | (ready_go[i] & allowin[i+1]);
        end
    end

    // kill[i] is set when any flush bit at or above i is set, so several
    // flush bits behave exactly like the highest one.
    always_comb begin
        kill           = '0;
        kill[STAGES-1] = flush[STAGES-1];
        for (int i = STAGES - 2; i >= 0; i--) begin
            kill[i] = kill[i+1] | flush[i];
        end
    end

    assign in_ready  = allowin[0] & ~(|flush);
    assign out_valid = valid_q[STAGES-1] & ready_go[STAGES-1];
    assign out_data  = data_q[STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= '0;
            retire_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            // Consume is judged on pre-flush state, so a flush of the oldest
            // stage never swallows a retire that happened in the same cycle.
            if (out_valid && out_ready) begin
                retire_q <= retire_q + 32'd1;
            end

            if (kill[0]) begin
                valid_q[0] <= 1'b0;
            end else if (in_valid && in_ready) begin
                valid_q[0] <= 1'b1;
                data_q[0]  <= in_data;
            end else if (allowin[0]) begin
                valid_q[0] <= 1'b0;
            end

            for (int i = 1; i < STAGES; i++) begin
                if (kill[i]) begin
                    valid_q[i] <= 1'b0;
                end else if (allowin[i]) begin
                    // A stage killed while moving forward hands on a bubble.
                    valid_q[i] <= valid_q[i-1] & ready_go[i-1] & ~kill[i-1];
                    data_q[i]  <= data_q[i-1];
                end
            end
        end
    end

    assign retire_cnt  = retire_q;
    assign stage_valid = valid_q;

    always_comb begin
        stage_data = '0;
        for (int i = 0; i < STAGES; i++) begin
            stage_data[i*WIDTH +: WIDTH] = data_q[i];
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    localparam int S = 5;
    localparam int W = 32;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic [W-1:0]     in_data;
    logic             in_ready;
    logic [S-1:0]     stall;
    logic [S-1:0]     flush;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic             out_ready;
    logic [S-1:0]     stage_valid;
    logic [S*W-1:0]   stage_data;
    logic [31:0]      retire_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    pipe_ctrl #(.STAGES(S), .WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .stall       (stall),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .stage_valid (stage_valid),
        .stage_data  (stage_data),
        .retire_cnt  (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [S*W-1:0] obs, input logic [S*W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        stall     = '0;
        flush     = '0;
        out_ready = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("rst_stage_valid", stage_valid, 0);
        chk("rst_out_valid",   out_valid,   0);
        chk("rst_retire",      retire_cnt,  0);
        chk("rst_stage_data",  stage_data,  0);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("rst_in_ready", in_ready, 1);

        // Streaming 1,2,3...: first output after exactly 5 edges.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            in_data = n;
            tick();
            if (n < 5) begin
                chk("lat_out_valid_low", out_valid, 0);
            end else begin
                chk("stream_out_valid", out_valid, 1);
                chk("stream_out_data",  out_data,  n - 4);
                chk("stream_retire",    retire_cnt, (n > 5) ? n - 5 : 0);
            end
        end

        // Backpressure: full pipe 12..8, out_ready low 3 cycles.
        out_ready = 1'b0;
        in_data   = 13;
        #1 chk("bp_in_ready_low", in_ready, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_frozen", stage_data, {32'd8, 32'd9, 32'd10, 32'd11, 32'd12});
            chk("bp_out_data", out_data, 8);
            chk("bp_retire", retire_cnt, 7);
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_data = 13 + k;
            tick();
            chk("bp_resume_data",   out_data,   9 + k);
            chk("bp_resume_retire", retire_cnt, 8 + k);
        end

        // Stall stage 2 one cycle with pipe 17..13.
        stall   = 5'b00100;
        in_data = 18;
        #1 chk("stall_in_ready", in_ready, 0);
        tick();
        chk("stall_valid", stage_valid, 5'b10111);
        chk("stall_out_data", out_data, 14);
        chk("stall_retire", retire_cnt, 13);
        stall = '0;
        tick();
        chk("gap_out_valid", out_valid, 0);
        chk("gap_valid", stage_valid, 5'b01111);
        chk("gap_retire", retire_cnt, 14);
        in_data = 19;
        tick();
        chk("post_gap_data", out_data, 15);
        chk("post_gap_retire", retire_cnt, 14);
        in_data = 20;
        tick();
        chk("post_gap_data2", out_data, 16);
        chk("post_gap_retire2", retire_cnt, 15);

        // Retire counter wrap.
        force dut.retire_q = 32'hFFFF_FFFF;
        #1 release dut.retire_q;
        #1 chk("wrap_preload", retire_cnt, 32'hFFFF_FFFF);
        in_data = 21;
        tick();
        chk("wrap_zero", retire_cnt, 0);
        chk("wrap_out_data", out_data, 17);

        // Reset pulse between edges while full.
        #2 reset = 1'b1;
        #1;
        chk("midrst_valid", stage_valid, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_retire", retire_cnt, 0);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("midrst_in_ready", in_ready, 1);
        for (int n = 5; n <= 9; n++) begin
            in_data = n;
            tick();
            if (n < 9) chk("refill_out_valid_low", out_valid, 0);
        end
        chk("refill_out_valid", out_valid, 1);
        chk("refill_out_data", out_data, 5);
        chk("refill_retire", retire_cnt, 0);

        // Flush with stages 0..4 holding 9..5; bits 0 and 2 act as bit 2.
        out_ready = 1'b0;
        flush     = 5'b00101;
        in_data   = 10;
        #1 chk("flush_in_ready", in_ready, 0);
        tick();
        chk("flush_valid", stage_valid, 5'b11000);
        chk("flush_s3", stage_data[3*W +: W], 6);
        chk("flush_out_data", out_data, 5);
        flush     = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("flush_drain_data", out_data, 6);
        chk("flush_drain_valid", stage_valid, 5'b10000);
        chk("flush_drain_retire", retire_cnt, 1);
        tick();
        chk("flush_empty", stage_valid, 0);
        chk("flush_empty_retire", retire_cnt, 2);

        // Flush of the oldest stage in the cycle it retires still counts.
        in_valid = 1'b1;
        for (int n = 30; n <= 34; n++) begin
            in_data = n;
            tick();
        end
        chk("f4_out_data", out_data, 30);
        in_valid = 1'b0;
        flush    = 5'b10000;
        #1 chk("f4_out_valid", out_valid, 1);
        tick();
        chk("f4_retire", retire_cnt, 3);
        chk("f4_valid", stage_valid, 0);
        flush = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
